dcache_1way_ctrl: RTL and testbench

//   Direct-mapped, write-back, write-allocate data cache with its controller FSM, in the MEM stage.

---
 rtl/dcache_1way_ctrl_if.sv | 27 ++
 rtl/dcache_1way_ctrl.sv | 109 ++++++++++
 tb/tb_dcache_1way_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_1way_ctrl_if.sv
// dcache_1way_ctrl_if: MEM-stage CPU port and line-wide data-memory port of the direct-mapped cache
interface dcache_1way_ctrl_if #(
    parameter int LINE_BITS = 256
);
    logic                 p1_req_i;
    logic                 p1_we_i;
    logic [31:0]          p1_addr_i;
    logic [31:0]          p1_wdata_i;
    logic [31:0]          p1_rdata_o;
    logic                 p1_stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic                 mem_ack_i;
    logic [LINE_BITS-1:0] mem_rdata_i;

    modport slave (
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, mem_ack_i, mem_rdata_i,
        output p1_rdata_o, p1_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, mem_ack_i, mem_rdata_i,
        input  p1_rdata_o, p1_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_1way_ctrl.sv
// dcache_1way_ctrl: direct-mapped write-back write-allocate data cache with miss FSM
module dcache_1way_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_1way_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WRD_W = OFF_W - 2;
    localparam logic [OFF_W-1:0] ZOFF = '0;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [WRD_W-1:0] word;
    logic             idle, hit, miss, victim_dirty, wr_hit, fill, unused_addr;

    assign idx          = bus.p1_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign tag          = bus.p1_addr_i[31:OFF_W+IDX_W];
    assign word         = bus.p1_addr_i[OFF_W-1:2];
    assign unused_addr  = ^bus.p1_addr_i[1:0];
    assign idle         = state_q == IDLE;
    assign hit          = bus.p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign miss         = idle & bus.p1_req_i & ~hit;
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign wr_hit       = idle & hit & bus.p1_we_i;
    assign fill         = (state_q == ALLOCATE) & bus.mem_ack_i;

    assign bus.p1_stall_o  = (bus.p1_req_i & ~hit) | ~idle;
    assign bus.p1_rdata_o  = data_q[idx][{word, 5'b0} +: 32];
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        if (miss) begin
            state_d     = victim_dirty ? WRITEBACK : ALLOCATE;
            mem_req_d   = 1'b1;
            mem_we_d    = victim_dirty;
            mem_addr_d  = victim_dirty ? {tag_q[idx], idx, ZOFF} : {tag, idx, ZOFF};
            mem_wdata_d = data_q[idx];
        end
        // Writeback done: re-issue straight away as the refill of the requested line.
        if ((state_q == WRITEBACK) & bus.mem_ack_i) begin
            state_d    = ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, ZOFF};
        end
        if (fill) begin
            state_d      = IDLE;
            mem_req_d    = 1'b0;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
        if (wr_hit) dirty_d[idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Tags and data carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[idx] <= bus.mem_rdata_i;
            tag_q[idx]  <= tag;
        end else if (wr_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= bus.p1_wdata_i;
        end
    end
endmodule

// File: tb/tb_dcache_1way_ctrl.sv
// tb_dcache_1way_ctrl: vector table plus reset/stray-ack sequences, memory requests checked by a scoreboard
module tb_dcache_1way_ctrl;
    localparam int D = 5;
    localparam int CLEAN = D + 2;
    localparam int DIRTY = 2 * D + 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic        wchk;
        int          woff;
        logic [31:0] wword;
    } req_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          nreq;
        logic [31:0] wb_addr;
        int          wb_woff;
        logic [31:0] wb_word;
        logic [31:0] rd_addr;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dcache_1way_ctrl_if #(.LINE_BITS(256)) bus ();

    dcache_1way_ctrl #(.NUM_LINES(32), .LINE_BITS(256)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    req_t         exp_q[$];
    logic [255:0] mem [logic [31:0]];
    vec_t         vecs [14];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         mdl_ack = 1'b0;
    logic         stray_ack = 1'b0;
    logic [255:0] mdl_rdata = '0;
    logic         mdl_busy = 1'b0;
    int           mdl_cnt = 0;
    logic [31:0]  mdl_addr = '0;

    assign bus.mem_ack_i   = mdl_ack | stray_ack;
    assign bus.mem_rdata_i = mdl_rdata;

    function automatic logic [255:0] pat_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hC0DE_0000 | 32'(a[15:0] + 16'(w * 4));
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Memory model: acks D cycles after a request appears, pops the scoreboard on each new request.
    initial begin
        req_t e;
        forever begin
            @(negedge clk_i);
            mdl_ack = 1'b0;
            if (!rst_i || !bus.mem_req_o) begin
                mdl_busy = 1'b0;
            end else if (!mdl_busy) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 0;
                mdl_addr = bus.mem_addr_o;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_req: got addr %h we %0b, expected none", mdl_addr, bus.mem_we_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", 32'(bus.mem_we_o), 32'(e.we));
                    chk("req_addr", mdl_addr, e.addr);
                    if (e.wchk) chk("wb_word", bus.mem_wdata_o[e.woff*32 +: 32], e.wword);
                end
            end else begin
                mdl_cnt++;
                chk("req_addr_held", bus.mem_addr_o, mdl_addr);
                if (mdl_cnt == D) begin
                    mdl_ack  = 1'b1;
                    mdl_busy = 1'b0;
                    if (bus.mem_we_o) mem[mdl_addr] = bus.mem_wdata_o;
                    else mdl_rdata = mem.exists(mdl_addr) ? mem[mdl_addr] : pat_line(mdl_addr);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rd);
        @(negedge clk_i);
        bus.p1_req_i   = 1'b1;
        bus.p1_we_i    = we;
        bus.p1_addr_i  = addr;
        bus.p1_wdata_i = wdata;
        stalls = 0;
        #1;
        while (bus.p1_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        rd = bus.p1_rdata_o;
    endtask

    task automatic do_vec(input string nm, input vec_t v);
        int          stalls;
        logic [31:0] rd;
        if (v.nreq == 2) exp_q.push_back('{1'b1, v.wb_addr, 1'b1, v.wb_woff, v.wb_word});
        if (v.nreq >= 1) exp_q.push_back('{1'b0, v.rd_addr, 1'b0, 0, 32'h0});
        access(v.we, v.addr, v.wdata, stalls, rd);
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        if (v.chk_rd) chk({nm, "_rdata"}, rd, v.exp_rd);
        chk({nm, "_pending_reqs"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] l;
        bus.p1_req_i   = 1'b0;
        bus.p1_we_i    = 1'b0;
        bus.p1_addr_i  = '0;
        bus.p1_wdata_i = '0;
        l = pat_line(32'h40);
        l[63:32] = 32'h1111_2222;
        mem[32'h40] = l;
        vecs[0]  = '{1'b0, 32'h040, 32'h0,         1'b1, 32'hC0DE_0040, CLEAN, 1, 32'h0,   0, 32'h0,         32'h040};
        vecs[1]  = '{1'b0, 32'h044, 32'h0,         1'b1, 32'h1111_2222, 0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 32'h044, 32'hDEADBEEF,  1'b0, 32'h0,         0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h044, 32'h0,         1'b1, 32'hDEADBEEF,  0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 32'h440, 32'h0,         1'b1, 32'hC0DE_0440, DIRTY, 2, 32'h040, 1, 32'hDEADBEEF,  32'h440};
        vecs[5]  = '{1'b0, 32'h840, 32'h0,         1'b1, 32'hC0DE_0840, CLEAN, 1, 32'h0,   0, 32'h0,         32'h840};
        vecs[6]  = '{1'b1, 32'h848, 32'h1234_5678, 1'b0, 32'h0,         0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 32'h848, 32'h0,         1'b1, 32'h1234_5678, 0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h044, 32'h0,         1'b1, 32'hDEADBEEF,  DIRTY, 2, 32'h840, 2, 32'h1234_5678, 32'h040};
        vecs[9]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0,         CLEAN, 1, 32'h0,   0, 32'h0,         32'h1000};
        vecs[10] = '{1'b0, 32'h1000, 32'h0,        1'b1, 32'hCAFEF00D,  0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 32'h1004, 32'h0,        1'b1, 32'hC0DE_1004, 0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 32'h3E0, 32'h0,         1'b1, 32'hC0DE_03E0, CLEAN, 1, 32'h0,   0, 32'h0,         32'h3E0};
        vecs[13] = '{1'b0, 32'h3FC, 32'h0,         1'b1, 32'hC0DE_03FC, 0,     0, 32'h0,   0, 32'h0,         32'h0};

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_stall", 32'(bus.p1_stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 14; i++) do_vec($sformatf("v%0d", i), vecs[i]);

        // Asynchronous reset in the middle of a refill.
        exp_q.push_back('{1'b0, 32'h840, 1'b0, 0, 32'h0});
        @(negedge clk_i);
        bus.p1_we_i   = 1'b0;
        bus.p1_addr_i = 32'h840;
        #1;
        chk("miss_stall_same_cycle", 32'(bus.p1_stall_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
        chk("alloc_req", 32'(bus.mem_req_o), 32'd1);
        chk("alloc_addr", bus.mem_addr_o, 32'h840);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("arst_mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("arst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("arst_req_seen", 32'(exp_q.size()), 32'd0);
        bus.p1_req_i = 1'b0;
        #1;
        chk("arst_stall_idle", 32'(bus.p1_stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        do_vec("post_rst_0x848", '{1'b0, 32'h848, 32'h0, 1'b1, 32'h1234_5678, CLEAN, 1, 32'h0, 0, 32'h0, 32'h840});
        do_vec("post_rst_0x1000", '{1'b0, 32'h1000, 32'h0, 1'b1, 32'hC0DE_1000, CLEAN, 1, 32'h0, 0, 32'h0, 32'h1000});

        // Stray ack while idle must not touch any line.
        @(negedge clk_i);
        bus.p1_req_i  = 1'b0;
        bus.p1_addr_i = 32'h848;
        stray_ack     = 1'b1;
        #1;
        chk("stray_stall", 32'(bus.p1_stall_o), 32'd0);
        @(negedge clk_i);
        stray_ack = 1'b0;
        #1;
        chk("stray_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("stray_stall_after", 32'(bus.p1_stall_o), 32'd0);
        do_vec("stray_0x848", '{1'b0, 32'h848, 32'h0, 1'b1, 32'h1234_5678, 0, 0, 32'h0, 0, 32'h0, 32'h0});
        do_vec("stray_0x1000", '{1'b0, 32'h1000, 32'h0, 1'b1, 32'hC0DE_1000, 0, 0, 32'h0, 0, 32'h0, 32'h0});

        @(negedge clk_i);
        bus.p1_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
